// File: rtl/basket_pkg.sv
// Shared types and constants for the basket manager: command encodings, slot layout,
// catalogue price table and the derived width-exact constants used by the datapath.
package basket_pkg;

   localparam int unsigned NUM_OF_PRDCT = 12;
   localparam int unsigned ID_WIDTH     = 4;
   localparam int unsigned QTY_WIDTH    = 4;
   localparam int unsigned PRICE_WIDTH  = 20;
   localparam int unsigned MAX_QTY      = 9;
   localparam int unsigned CNT_WIDTH    = 4;

   typedef enum logic [1:0] {
      OP_ADD    = 2'b00,
      OP_REMOVE = 2'b01,
      OP_CLEAR  = 2'b10,
      OP_NOP    = 2'b11
   } op_e;

   typedef logic [PRICE_WIDTH-1:0] price_t;

   localparam logic [ID_WIDTH-1:0]  EMPTY_ID  = 4'hF;
   localparam logic [ID_WIDTH-1:0]  ID_LIMIT  = ID_WIDTH'(NUM_OF_PRDCT);
   localparam logic [QTY_WIDTH-1:0] QTY_ONE   = QTY_WIDTH'(1);
   localparam logic [QTY_WIDTH-1:0] QTY_MAX   = QTY_WIDTH'(MAX_QTY);
   localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(NUM_OF_PRDCT);
   localparam logic [CNT_WIDTH-1:0] SLOT_LAST = CNT_WIDTH'(NUM_OF_PRDCT - 1);
   // Basket size at which the optional discount applies
   localparam logic [CNT_WIDTH-1:0] DISCOUNT_MIN_CNT = CNT_WIDTH'(5);

   // price[i] = 100 * (i + 1)
   localparam price_t PRICE_TABLE [NUM_OF_PRDCT] = '{
      20'd100, 20'd200, 20'd300, 20'd400, 20'd500,  20'd600,
      20'd700, 20'd800, 20'd900, 20'd1000, 20'd1100, 20'd1200
   };

   typedef struct packed {
      logic [ID_WIDTH-1:0]  id;
      logic [QTY_WIDTH-1:0] qty;
      price_t               subtotal;
   } slot_t;

   localparam slot_t EMPTY_SLOT = {EMPTY_ID, {QTY_WIDTH{1'b0}}, {PRICE_WIDTH{1'b0}}};

endpackage

// File: rtl/basket_price_rom.sv
// Catalogue price lookup and slot subtotal (qty * price) for the slot being updated.
// IDs outside the catalogue price at zero; the caller rejects them anyway.
module basket_price_rom
   import basket_pkg::*;
(
   input  logic [ID_WIDTH-1:0]  id,
   input  logic [QTY_WIDTH-1:0] qty,
   output price_t               subtotal
);

   price_t price;

   // Guarded table lookup so an out-of-range ID never indexes past the table
   always_comb begin
      price = '0;
      if (id < ID_LIMIT) begin
         price = PRICE_TABLE[id];
      end
   end

   // MAX_QTY * top price stays far below 2**PRICE_WIDTH, so a PRICE_WIDTH product is exact
   assign subtotal = {{(PRICE_WIDTH - QTY_WIDTH){1'b0}}, qty} * price;

endmodule

// File: rtl/basket_manager.sv
// Shopping basket for the VGA display path: up to NUM_OF_PRDCT (id, qty) slots in insertion
// order, updated by ADD/REMOVE/CLEAR commands, with the total re-summed one slot per cycle.
// Optional build macro BASKET_DISCOUNT_EN: 12.5% off the total when 5+ slots are occupied.
module basket_manager
   import basket_pkg::*;
(
   input  logic                                CLOCK_50,
   input  logic                                RESET,
   input  logic                                cmd_valid,
   output logic                                cmd_ready,
   input  logic [1:0]                          cmd_op,
   input  logic [ID_WIDTH-1:0]                 cmd_id,
   output logic                                cmd_err,
   output logic                                busy,
   output logic [3:0]                          BasketProductNum,
   output logic [NUM_OF_PRDCT*ID_WIDTH-1:0]    BasketProductIDList,
   output logic [NUM_OF_PRDCT*PRICE_WIDTH-1:0] numbers,
   output logic [PRICE_WIDTH-1:0]              total_price
);

   typedef enum logic [1:0] {StIdle, StUpdate, StSum, StDone} state_e;

   state_e               state_q;
   op_e                  op_q;
   logic [ID_WIDTH-1:0]  id_q;
   slot_t                slots_q [NUM_OF_PRDCT];
   logic [CNT_WIDTH-1:0] count_q;
   logic [CNT_WIDTH-1:0] idx_q;
   price_t               acc_q;
   price_t               total_q;
   logic                 cmd_ready_q;
   logic                 cmd_err_q;

   logic                 hit;
   logic [CNT_WIDTH-1:0] hit_idx;
   slot_t                hit_slot;
   logic [QTY_WIDTH-1:0] qty_new;
   price_t               rom_subtotal;
   logic                 id_ok;
   slot_t                touched;
   slot_t                slots_upd [NUM_OF_PRDCT];
   logic [CNT_WIDTH-1:0] count_upd;
   logic                 reject;
   logic [PRICE_WIDTH:0] acc_sum;
   price_t               acc_next;
   price_t               total_next;

   // Find the latched ID among the occupied slots
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < NUM_OF_PRDCT; i++) begin
         if (!hit && (CNT_WIDTH'(i) < count_q) && (slots_q[i].id == id_q)) begin
            hit     = 1'b1;
            hit_idx = CNT_WIDTH'(i);
         end
      end
   end

   assign hit_slot = slots_q[hit_idx];
   assign id_ok    = (id_q < ID_LIMIT);

   // New quantity of the touched slot: a fresh append always starts at one
   always_comb begin
      qty_new = QTY_ONE;
      if (hit) begin
         qty_new = (op_q == OP_ADD) ? hit_slot.qty + QTY_ONE : hit_slot.qty - QTY_ONE;
      end
   end

   basket_price_rom u_price_rom (
      .id       (id_q),
      .qty      (qty_new),
      .subtotal (rom_subtotal)
   );

   // Candidate list after the latched command; only committed when not rejected
   always_comb begin
      slots_upd        = slots_q;
      count_upd        = count_q;
      reject           = 1'b0;
      touched.id       = id_q;
      touched.qty      = qty_new;
      touched.subtotal = rom_subtotal;
      case (op_q)
         OP_ADD: begin
            if (!id_ok || (hit && (hit_slot.qty == QTY_MAX)) || (!hit && (count_q == CNT_FULL))) begin
               reject = 1'b1;
            end else if (hit) begin
               slots_upd[hit_idx] = touched;
            end else begin
               slots_upd[count_q] = touched;
               count_upd          = count_q + CNT_WIDTH'(1);
            end
         end
         OP_REMOVE: begin
            if (!id_ok || !hit) begin
               reject = 1'b1;
            end else if (qty_new != '0) begin
               slots_upd[hit_idx] = touched;
            end else begin
               // Close the gap so slot order stays oldest-first
               for (int i = 0; i < NUM_OF_PRDCT - 1; i++) begin
                  if (CNT_WIDTH'(i) >= hit_idx) begin
                     slots_upd[i] = slots_q[i+1];
                  end
               end
               slots_upd[NUM_OF_PRDCT-1] = EMPTY_SLOT;
               count_upd                 = count_q - CNT_WIDTH'(1);
            end
         end
         OP_CLEAR: begin
            for (int i = 0; i < NUM_OF_PRDCT; i++) begin
               slots_upd[i] = EMPTY_SLOT;
            end
            count_upd = '0;
         end
         default: ;
      endcase
   end

   // Saturating accumulate of the slot currently addressed by the sweep
   assign acc_sum  = {1'b0, acc_q} + {1'b0, slots_q[idx_q].subtotal};
   assign acc_next = acc_sum[PRICE_WIDTH] ? '1 : acc_sum[PRICE_WIDTH-1:0];

`ifdef BASKET_DISCOUNT_EN
   // acc - acc/8 with floor truncation
   assign total_next = (count_q >= DISCOUNT_MIN_CNT) ? acc_q - (acc_q >> 3) : acc_q;
`else
   assign total_next = acc_q;
`endif

   // Command FSM: accept, commit the list update, sweep subtotals, publish the total
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state_q     <= StIdle;
         op_q        <= OP_NOP;
         id_q        <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         acc_q       <= '0;
         total_q     <= '0;
         cmd_ready_q <= 1'b1;
         cmd_err_q   <= 1'b0;
         for (int i = 0; i < NUM_OF_PRDCT; i++) begin
            slots_q[i] <= EMPTY_SLOT;
         end
      end else begin
         cmd_err_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (cmd_valid && cmd_ready_q) begin
                  op_q        <= op_e'(cmd_op);
                  id_q        <= cmd_id;
                  cmd_ready_q <= 1'b0;
                  state_q     <= StUpdate;
               end
            end
            StUpdate: begin
               if (reject) begin
                  cmd_err_q   <= 1'b1;
                  cmd_ready_q <= 1'b1;
                  state_q     <= StIdle;
               end else begin
                  slots_q <= slots_upd;
                  count_q <= count_upd;
                  if (op_q == OP_CLEAR) begin
                     total_q <= '0;
                  end
                  acc_q   <= '0;
                  idx_q   <= '0;
                  state_q <= StSum;
               end
            end
            StSum: begin
               acc_q <= acc_next;
               if (idx_q == SLOT_LAST) begin
                  state_q <= StDone;
               end else begin
                  idx_q <= idx_q + CNT_WIDTH'(1);
               end
            end
            StDone: begin
               total_q     <= total_next;
               cmd_ready_q <= 1'b1;
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Flatten the slot list onto the display buses
   always_comb begin
      BasketProductIDList = '0;
      numbers             = '0;
      for (int i = 0; i < NUM_OF_PRDCT; i++) begin
         BasketProductIDList[i*ID_WIDTH +: ID_WIDTH] = slots_q[i].id;
         numbers[i*PRICE_WIDTH +: PRICE_WIDTH]       = slots_q[i].subtotal;
      end
   end

   assign cmd_ready        = cmd_ready_q;
   assign busy             = ~cmd_ready_q;
   assign cmd_err          = cmd_err_q;
   assign BasketProductNum = count_q;
   assign total_price      = total_q;

endmodule

// File: tb/tb_basket_manager.sv
// Self-checking bench for basket_manager: a behavioural basket model pushes the expected
// post-command snapshot to a queue; each scenario pops and compares once the DUT finishes.
module tb_basket_manager;
   import basket_pkg::*;

   logic         CLOCK_50;
   logic         RESET;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [3:0]   cmd_id;
   logic         cmd_err;
   logic         busy;
   logic [3:0]   BasketProductNum;
   logic [47:0]  BasketProductIDList;
   logic [239:0] numbers;
   logic [19:0]  total_price;

   basket_manager dut (
      .CLOCK_50            (CLOCK_50),
      .RESET               (RESET),
      .cmd_valid           (cmd_valid),
      .cmd_ready           (cmd_ready),
      .cmd_op              (cmd_op),
      .cmd_id              (cmd_id),
      .cmd_err             (cmd_err),
      .busy                (busy),
      .BasketProductNum    (BasketProductNum),
      .BasketProductIDList (BasketProductIDList),
      .numbers             (numbers),
      .total_price         (total_price)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   typedef struct packed {
      logic         err;
      logic [7:0]   cyc;
      logic [3:0]   cnt;
      logic [47:0]  ids;
      logic [239:0] nums;
      logic [19:0]  tot;
   } snap_t;

   snap_t exp_q[$];
   int    n_cmp  = 0;
   int    n_fail = 0;

   // Behavioural basket
   int m_id  [12];
   int m_qty [12];
   int m_count = 0;
   int m_total = 0;

   function automatic int price_of(int id);
      return 100 * (id + 1);
   endfunction

   function automatic void model_reset();
      m_count = 0;
      m_total = 0;
   endfunction

   // Applies a command to the model; returns 1 when it must be rejected
   function automatic bit model_apply(logic [1:0] op, int id);
      int j = -1;
      for (int k = 0; k < m_count; k++) if (m_id[k] == id) j = k;
      case (op)
         OP_ADD: begin
            if (id >= 12) return 1'b1;
            if (j >= 0) begin
               if (m_qty[j] == 9) return 1'b1;
               m_qty[j]++;
            end else begin
               if (m_count == 12) return 1'b1;
               m_id[m_count]  = id;
               m_qty[m_count] = 1;
               m_count++;
            end
         end
         OP_REMOVE: begin
            if (id >= 12 || j < 0) return 1'b1;
            m_qty[j]--;
            if (m_qty[j] == 0) begin
               for (int k = j; k < m_count - 1; k++) begin
                  m_id[k]  = m_id[k+1];
                  m_qty[k] = m_qty[k+1];
               end
               m_count--;
            end
         end
         OP_CLEAR: m_count = 0;
         default: ;
      endcase
      return 1'b0;
   endfunction

   function automatic snap_t model_snap(bit e);
      snap_t s;
      int    t = 0;
      s.err  = e;
      s.cyc  = e ? 8'd1 : 8'd14;
      s.cnt  = 4'(m_count);
      s.ids  = '1;
      s.nums = '0;
      for (int k = 0; k < m_count; k++) begin
         s.ids[k*4 +: 4]    = 4'(m_id[k]);
         s.nums[k*20 +: 20] = 20'(m_qty[k] * price_of(m_id[k]));
         t += m_qty[k] * price_of(m_id[k]);
      end
`ifdef BASKET_DISCOUNT_EN
      if (m_count >= 5) t = t - t / 8;
`endif
      if (!e) m_total = t;
      s.tot = 20'(m_total);
      return s;
   endfunction

   function automatic snap_t observe(logic [7:0] cyc);
      snap_t s;
      s.err  = cmd_err;
      s.cyc  = cyc;
      s.cnt  = BasketProductNum;
      s.ids  = BasketProductIDList;
      s.nums = numbers;
      s.tot  = total_price;
      return s;
   endfunction

   // Pushes the expected result, performs one handshake and waits (bounded) for completion
   task automatic run_cmd(input logic [1:0] op, input int id, output snap_t got);
      bit         e;
      int         guard = 0;
      logic [7:0] cyc   = 0;
      e = model_apply(op, id);
      exp_q.push_back(model_snap(e));
      while (cmd_ready !== 1'b1 && guard < 100) begin
         @(negedge CLOCK_50);
         guard++;
      end
      @(negedge CLOCK_50);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_id    = 4'(id);
      @(posedge CLOCK_50);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      for (int n = 0; n < 40; n++) begin
         @(posedge CLOCK_50);
         #1;
         cyc++;
         if (cmd_err === 1'b1 || cmd_ready === 1'b1) break;
      end
      got = observe(cyc);
   endtask

   task automatic test_reset;
      RESET = 1'b1;
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      n_cmp++; if (BasketProductNum !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", BasketProductNum); end
      n_cmp++; if (BasketProductIDList !== 48'hFFFF_FFFF_FFFF) begin n_fail++; $display("FAIL reset_ids: got %h want ffffffffffff", BasketProductIDList); end
      n_cmp++; if (numbers !== '0) begin n_fail++; $display("FAIL reset_numbers: got %h want 0", numbers); end
      n_cmp++; if (total_price !== 20'd0) begin n_fail++; $display("FAIL reset_total: got %0d want 0", total_price); end
      n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got ready=%b busy=%b err=%b want 1 0 0", cmd_ready, busy, cmd_err); end
      RESET = 1'b0;
      model_reset();
   endtask

   task automatic test_adds;
      int    ids [3] = '{3, 3, 0};
      snap_t got, want;
      for (int k = 0; k < 3; k++) begin
         run_cmd(OP_ADD, ids[k], got);
         want = exp_q.pop_front();
         n_cmp++;
         if (got !== want) begin n_fail++; $display("FAIL add_%0d: got %h want %h", ids[k], got, want); end
      end
      n_cmp++;
      if (BasketProductNum !== 4'd2 || BasketProductIDList[7:0] !== 8'h03 || numbers[19:0] !== 20'd800 ||
          numbers[39:20] !== 20'd100 || total_price !== 20'd900) begin
         n_fail++;
         $display("FAIL adds_final: got cnt=%0d ids=%h s0=%0d s1=%0d tot=%0d want 2 03 800 100 900",
                  BasketProductNum, BasketProductIDList[7:0], numbers[19:0], numbers[39:20], total_price);
      end
   endtask

   task automatic test_remove;
      int    want_tot [2] = '{500, 100};
      snap_t got, want;
      for (int k = 0; k < 2; k++) begin
         run_cmd(OP_REMOVE, 3, got);
         want = exp_q.pop_front();
         n_cmp++;
         if (got !== want) begin n_fail++; $display("FAIL remove3_%0d: got %h want %h", k, got, want); end
         n_cmp++;
         if (total_price !== 20'(want_tot[k])) begin n_fail++; $display("FAIL remove3_total_%0d: got %0d want %0d", k, total_price, want_tot[k]); end
      end
      n_cmp++;
      if (BasketProductNum !== 4'd1 || BasketProductIDList[7:0] !== 8'hF0 || numbers[39:0] !== {20'd0, 20'd100}) begin
         n_fail++;
         $display("FAIL compaction: got cnt=%0d ids=%h nums=%h want 1 f0 0000000064", BasketProductNum, BasketProductIDList[7:0], numbers[39:0]);
      end
   endtask

   task automatic test_errors;
      snap_t got, want;
      run_cmd(OP_ADD, 12, got);
      want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_fail++; $display("FAIL add_bad_id: got %h want %h", got, want); end
      run_cmd(OP_REMOVE, 5, got);
      want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_fail++; $display("FAIL remove_absent: got %h want %h", got, want); end
      for (int k = 1; k <= 10; k++) begin
         run_cmd(OP_ADD, 7, got);
         want = exp_q.pop_front();
         n_cmp++;
         if (got !== want || got.err !== (k == 10)) begin n_fail++; $display("FAIL add7_%0d: got %h want %h", k, got, want); end
      end
      n_cmp++;
      if (numbers[39:20] !== 20'(9 * price_of(7)) || BasketProductIDList[7:4] !== 4'd7) begin
         n_fail++;
         $display("FAIL add7_sat: got id=%0d sub=%0d want 7 %0d", BasketProductIDList[7:4], numbers[39:20], 9 * price_of(7));
      end
   endtask

   task automatic test_nop;
      snap_t got, want;
      run_cmd(OP_NOP, 0, got);
      want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_fail++; $display("FAIL nop: got %h want %h", got, want); end
   endtask

   // CLEAR presented while busy must wait for cmd_ready, then be taken
   task automatic test_busy;
      snap_t      got, want;
      bit         e;
      logic [7:0] cyc = 0;
      e = model_apply(OP_ADD, 1);
      exp_q.push_back(model_snap(e));
      @(negedge CLOCK_50);
      cmd_valid = 1'b1;
      cmd_op    = OP_ADD;
      cmd_id    = 4'd1;
      @(posedge CLOCK_50);
      #1;
      cmd_op = OP_CLEAR;
      cmd_id = 4'd0;
      for (int n = 0; n < 40; n++) begin
         @(posedge CLOCK_50);
         #1;
         cyc++;
         if (cmd_err === 1'b1 || cmd_ready === 1'b1) break;
      end
      got  = observe(cyc);
      want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_fail++; $display("FAIL busy_add: got %h want %h", got, want); end
      e = model_apply(OP_CLEAR, 0);
      exp_q.push_back(model_snap(e));
      @(posedge CLOCK_50);
      #1;
      n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_clear_accept: got ready=%b want 0", cmd_ready); end
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      cyc       = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge CLOCK_50);
         #1;
         cyc++;
         if (cmd_err === 1'b1 || cmd_ready === 1'b1) break;
      end
      got  = observe(cyc);
      want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_fail++; $display("FAIL busy_clear: got %h want %h", got, want); end
   endtask

   // RESET on E5 of an ADD discards everything, including the old total
   task automatic test_reset_mid;
      snap_t got, want;
      run_cmd(OP_ADD, 5, got);
      want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_fail++; $display("FAIL pre_reset_add: got %h want %h", got, want); end
      @(negedge CLOCK_50);
      cmd_valid = 1'b1;
      cmd_op    = OP_ADD;
      cmd_id    = 4'd6;
      @(posedge CLOCK_50);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      repeat (4) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      RESET = 1'b1;
      @(posedge CLOCK_50);
      #1;
      RESET = 1'b0;
      model_reset();
      n_cmp++;
      if (BasketProductNum !== 4'd0 || BasketProductIDList !== 48'hFFFF_FFFF_FFFF || numbers !== '0 ||
          total_price !== 20'd0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got cnt=%0d ids=%h tot=%0d ready=%b busy=%b want 0 ffffffffffff 0 1 0",
                  BasketProductNum, BasketProductIDList, total_price, cmd_ready, busy);
      end
      repeat (16) @(posedge CLOCK_50);
      #1;
      n_cmp++;
      if (total_price !== 20'd0 || BasketProductNum !== 4'd0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_settle: got tot=%0d cnt=%0d ready=%b want 0 0 1", total_price, BasketProductNum, cmd_ready);
      end
   endtask

   task automatic test_discount;
      snap_t got, want;
      int    five_tot;
`ifdef BASKET_DISCOUNT_EN
      five_tot = 1313;
`else
      five_tot = 1500;
`endif
      for (int k = 0; k < 5; k++) begin
         run_cmd(OP_ADD, k, got);
         want = exp_q.pop_front();
         n_cmp++; if (got !== want) begin n_fail++; $display("FAIL disc5_add_%0d: got %h want %h", k, got, want); end
      end
      n_cmp++; if (total_price !== 20'(five_tot)) begin n_fail++; $display("FAIL disc5_total: got %0d want %0d", total_price, five_tot); end
      run_cmd(OP_CLEAR, 0, got);
      want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_fail++; $display("FAIL disc_clear: got %h want %h", got, want); end
      for (int k = 0; k < 4; k++) begin
         run_cmd(OP_ADD, k, got);
         want = exp_q.pop_front();
         n_cmp++; if (got !== want) begin n_fail++; $display("FAIL disc4_add_%0d: got %h want %h", k, got, want); end
      end
      n_cmp++; if (total_price !== 20'd1000) begin n_fail++; $display("FAIL disc4_total: got %0d want 1000", total_price); end
   endtask

   initial begin
      RESET     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      cmd_id    = 4'd0;
      test_reset();
      test_adds();
      test_remove();
      test_errors();
      test_nop();
      test_busy();
      test_reset_mid();
      test_discount();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion within time limit, want $finish before 1000000");
      $fatal(1, "watchdog expired");
   end

endmodule
